// File: rtl/regfile_wb_demux_if.sv
// Register-file bus: one write-back port and two combinational read ports.
interface regfile_wb_demux_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_0;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [DATA_W-1:0] rd_data_0;
    logic [DATA_W-1:0] rd_data_1;
    logic              wr_ack;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_0, rd_addr_1,
        input  rd_data_0, rd_data_1, wr_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_0, rd_addr_1,
        output rd_data_0, rd_data_1, wr_ack
    );
endinterface

// File: rtl/regfile_wb_demux.sv
// MIPS GPR file: 1-to-2**ADDR_W write-back demux, two combinational read ports,
// register 0 hardwired to zero, optional same-cycle write bypass.
module regfile_wb_demux #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter bit          WRITE_BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_demux_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic [DATA_W-1:0] rd_0;
    logic [DATA_W-1:0] rd_1;

    // One-hot write enables; register 0 never gets one, and reset suppresses all.
    always_comb begin
        wr_sel = '0;
        if (bus.wr_en && !rst && (bus.wr_addr != '0))
            wr_sel[bus.wr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[ADDR_W'(i)] <= '0;
            bus.wr_ack <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++)
                if (wr_sel[ADDR_W'(i)])
                    regs[ADDR_W'(i)] <= bus.wr_data;
            bus.wr_ack <= |wr_sel;
        end
    end

    // Bypass keys off wr_sel, so it inherits the reset and register-0 gating.
    always_comb begin
        rd_0 = regs[bus.rd_addr_0];
        if (WRITE_BYPASS && wr_sel[bus.rd_addr_0])
            rd_0 = bus.wr_data;
        if (bus.rd_addr_0 == '0)
            rd_0 = '0;
    end

    always_comb begin
        rd_1 = regs[bus.rd_addr_1];
        if (WRITE_BYPASS && wr_sel[bus.rd_addr_1])
            rd_1 = bus.wr_data;
        if (bus.rd_addr_1 == '0)
            rd_1 = '0;
    end

    assign bus.rd_data_0 = rd_0;
    assign bus.rd_data_1 = rd_1;
endmodule

// File: tb/tb_regfile_wb_demux.sv
// Scoreboard bench: two DUTs (no bypass / bypass) share stimulus; a reference
// model queues the expected per-cycle response and a negedge monitor compares.
module tb_regfile_wb_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_demux_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_wb_demux_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

    regfile_wb_demux #(.DATA_W(32), .ADDR_W(5), .WRITE_BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    regfile_wb_demux #(.DATA_W(32), .ADDR_W(5), .WRITE_BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        bit          check;
        logic [31:0] rd0_nb;
        logic [31:0] rd1_nb;
        logic [31:0] rd0_by;
        logic [31:0] rd1_by;
        logic        ack;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem [32];
    logic        ack_next = 1'b0;
    bit          model_valid = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference read: zero register, then bypass rule, then storage.
    function automatic logic [31:0] ref_read(input bit bypass, input bit r, input bit we,
                                             input int wa, input logic [31:0] wd, input int ra);
        if (ra == 0) return 32'h0;
        if (bypass && !r && we && wa == ra) return wd;
        return mem[ra];
    endfunction

    task automatic cycle(input bit r, input bit we, input int wa, input logic [31:0] wd,
                         input int ra0, input int ra1);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus0.wr_en = we;  bus0.wr_addr = 5'(wa); bus0.wr_data = wd;
        bus0.rd_addr_0 = 5'(ra0); bus0.rd_addr_1 = 5'(ra1);
        bus1.wr_en = we;  bus1.wr_addr = 5'(wa); bus1.wr_data = wd;
        bus1.rd_addr_0 = 5'(ra0); bus1.rd_addr_1 = 5'(ra1);
        e.check  = model_valid;
        e.rd0_nb = ref_read(1'b0, r, we, wa, wd, ra0);
        e.rd1_nb = ref_read(1'b0, r, we, wa, wd, ra1);
        e.rd0_by = ref_read(1'b1, r, we, wa, wd, ra0);
        e.rd1_by = ref_read(1'b1, r, we, wa, wd, ra1);
        e.ack    = ack_next;
        sb.push_back(e);
        // Effect of the coming clock edge.
        if (r) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            ack_next = 1'b0;
            model_valid = 1'b1;
        end else begin
            if (we && wa != 0) mem[wa] = wd;
            ack_next = we && (wa != 0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.check) begin
                chk("rd0_nobypass", bus0.rd_data_0, e.rd0_nb);
                chk("rd1_nobypass", bus0.rd_data_1, e.rd1_nb);
                chk("rd0_bypass",   bus1.rd_data_0, e.rd0_by);
                chk("rd1_bypass",   bus1.rd_data_1, e.rd1_by);
                chk("ack_nobypass", {31'h0, bus0.wr_ack}, {31'h0, e.ack});
                chk("ack_bypass",   {31'h0, bus1.wr_ack}, {31'h0, e.ack});
            end
        end
    end

    initial begin
        int wa, ra0, ra1;
        bit r, we;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;

        // Reset with a simultaneous write that must be discarded.
        cycle(1'b1, 1'b1, 5, 32'hDEADBEEF, 5, 0);
        cycle(1'b1, 1'b1, 5, 32'hDEADBEEF, 5, 5);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 0, 32'h0, i, 31 - i);

        // Writes to register 0 are dropped and never acknowledged.
        cycle(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0);
        cycle(1'b0, 1'b0, 0, 32'h0, 0, 0);

        // Fill every register, then sweep both ports.
        for (int i = 1; i < 32; i++)
            cycle(1'b0, 1'b1, i, 32'(i) * 32'h01010101, $urandom_range(31), i);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 0, 32'h0, i, 31 - i);

        // Read-during-write on register 8.
        cycle(1'b0, 1'b1, 8, 32'h00000011, 1, 2);
        cycle(1'b0, 1'b1, 8, 32'h00000022, 8, 8);
        cycle(1'b0, 1'b0, 0, 32'h0, 8, 0);

        // Dual read of the same register.
        cycle(1'b0, 1'b1, 17, 32'hCAFEF00D, 0, 0);
        cycle(1'b0, 1'b0, 0, 32'h0, 17, 17);

        // Disabled write leaves storage alone.
        cycle(1'b0, 1'b0, 3, 32'h12345678, 3, 3);
        cycle(1'b0, 1'b0, 3, 32'h12345678, 3, 0);

        // Mid-stream reset discards the pending write.
        cycle(1'b0, 1'b1, 9, 32'hA5A5A5A5, 9, 1);
        cycle(1'b1, 1'b1, 9, 32'h5A5A5A5A, 9, 17);
        cycle(1'b0, 1'b0, 0, 32'h0, 9, 17);

        // Randomized traffic with biased read-during-write addressing.
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(40) == 0);
            we  = ($urandom_range(3) != 0);
            wa  = ($urandom_range(7) == 0) ? 0 : $urandom_range(31);
            ra0 = ($urandom_range(3) == 0) ? wa : $urandom_range(31);
            ra1 = ($urandom_range(3) == 0) ? wa : $urandom_range(31);
            cycle(r, we, wa, $urandom, ra0, ra1);
        end
        cycle(1'b0, 1'b0, 0, 32'h0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_demux.md
Name: regfile_wb_demux

Overview:
- 32-entry × 32-bit MIPS general-purpose register file; the write side is a 1-to-32 demultiplexer that steers one write-back word into the register selected by a 5-bit address.
- It is the counterpart of the datapath source-select muxes: the muxes pick one word from many sources, and this block distributes one write-back word to one of many destinations.
- It sits between the write-back mux (RegDst/MemtoReg path) and the ALU operand inputs of the single-cycle core.
- Two combinational read ports, one clocked write port.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- WRITE_BYPASS, 0. When 1, a read of the register being written returns the incoming write data in the same cycle. When 0, it returns the stored (old) value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high; clears all registers.
- wr_en  input  1  write enable from control (RegWrite).
- wr_addr  input  ADDR_W  destination register (output of the RegDst mux).
- wr_data  input  DATA_W  write-back word (output of the MemtoReg mux).
- rd_addr_0  input  ADDR_W  read port 0 address (rs).
- rd_addr_1  input  ADDR_W  read port 1 address (rt).
- rd_data_0  output  DATA_W  read port 0 data.
- rd_data_1  output  DATA_W  read port 1 data.
- wr_ack  output  1  registered; high for exactly one cycle after a write that actually changed storage.

Behaviour:
- One clock, clk. Reset is synchronous and active-high: on a rising edge of clk with rst=1, all 32 registers go to 0 and wr_ack goes to 0.
  - rst has priority over a simultaneous wr_en.
  - Reset asserted mid-stream discards the pending write.
- Write decode: wr_addr is demultiplexed into 32 one-hot enables gated by wr_en. On a rising edge with rst=0 and wr_en=1, register[wr_addr] <= wr_data. All other registers hold.
- Register 0 is hardwired to zero:
  - A write to address 0 is discarded, and its enable is never generated.
  - Reads of address 0 always return 0, including under bypass.
- wr_ack:
  - Goes to 1 on the edge after a write with wr_en=1 and wr_addr≠0.
  - Goes to 0 otherwise, including for writes to register 0.
  - Latency is 1 cycle, and it is not sticky.
- Reads are purely combinational, with no clock latency: rd_data_n = register[rd_addr_n].
- Both read ports may address the same register, and both return the same value.
- Read-during-write (rd_addr_n == wr_addr, wr_en=1, wr_addr≠0, rst=0):
  - WRITE_BYPASS=0: the old stored value until the edge, then the new value.
  - WRITE_BYPASS=1: wr_data immediately, in the same cycle.
- Unknown-free: every output is defined from the first cycle after reset. Before the first reset, outputs are don't-care.
- No wrap-around or overflow conditions. All ADDR_W values are legal addresses.

Test Plan:
- rst=1 for 2 cycles with wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF -> after release, register 5 reads 0 and wr_ack=0; all 32 registers read 0.
- Write 32'hFFFFFFFF to reg 0, then read rd_addr_0=0 -> rd_data_0=0; wr_ack stays 0.
- Write reg i with value i*32'h01010101 for i=1..31, then sweep both read ports over all addresses -> every register returns its value; wr_ack pulses one cycle per write.
- With WRITE_BYPASS=0: reg 8 = 32'h00000011; in the same cycle write reg 8 = 32'h00000022 with rd_addr_0=8 -> 32'h11 before the edge, 32'h22 after.
- Repeat the previous case with WRITE_BYPASS=1 -> 32'h22 in the same cycle.
- Dual read: rd_addr_0=rd_addr_1=17 after writing 32'hCAFEF00D -> both ports return 32'hCAFEF00D.
- wr_en=0 with wr_addr=3, wr_data=32'h12345678 -> register 3 is unchanged and wr_ack=0.
